// File: rtl/urv_csr_unit.sv
// CSR execute unit: decodes CSR instructions, owns cycle/instret counters and
// scratch registers, and forwards writes of trap-owned CSRs as a one-cycle strobe.
module urv_csr_unit #(
  parameter int CNT_WIDTH   = 40,
  parameter int NUM_SCRATCH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 x_stall_i,
  input  logic                 x_kill_i,
  input  logic                 x_retire_i,
  input  logic                 d_is_csr_i,
  input  logic [2:0]           d_fun_i,
  input  logic [4:0]           d_csr_imm_i,
  input  logic [11:0]          d_csr_sel_i,
  input  logic [31:0]          d_rs1_i,
  input  logic [CNT_WIDTH-1:0] csr_time_i,
  input  logic [31:0]          csr_mstatus_i,
  input  logic [31:0]          csr_mip_i,
  input  logic [31:0]          csr_mie_i,
  input  logic [31:0]          csr_mtvec_i,
  input  logic [31:0]          csr_mepc_i,
  input  logic [31:0]          csr_mcause_i,
  output logic [31:0]          x_rd_o,
  output logic                 x_csr_we_o,
  output logic [11:0]          x_csr_sel_o,
  output logic [31:0]          x_csr_write_value_o,
  output logic                 x_illegal_o
);

  localparam int HW = CNT_WIDTH - 32;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [CNT_WIDTH-1:0] cycle_reg, cycle_next;
  logic [CNT_WIDTH-1:0] instret_reg, instret_next;
  logic [31:0]          scratch_q [NUM_SCRATCH];

  logic        accept, mapped, is_external, wr_req, illegal, do_write;
  logic        scr_hit;
  logic [4:0]  scr_idx;
  logic [31:0] old_val, in2, new_val;

  assign accept   = d_is_csr_i & ~x_stall_i & ~x_kill_i;
  // Set/clear with x0 / zimm=0 is a pure read and must not trip the read-only check.
  assign wr_req   = ~(d_fun_i[1] && (d_csr_imm_i == 5'd0));
  assign illegal  = ~mapped | (wr_req & (d_csr_sel_i[11:10] == 2'b11));
  assign do_write = accept & ~illegal & wr_req;

  always_comb begin
    old_val     = 32'd0;
    mapped      = 1'b0;
    is_external = 1'b0;
    scr_hit     = 1'b0;
    scr_idx     = 5'd0;
    case (d_csr_sel_i)
      12'h300: begin old_val = csr_mstatus_i; mapped = 1'b1; is_external = 1'b1; end
      12'h304: begin old_val = csr_mie_i;     mapped = 1'b1; is_external = 1'b1; end
      12'h305: begin old_val = csr_mtvec_i;   mapped = 1'b1; is_external = 1'b1; end
      12'h341: begin old_val = csr_mepc_i;    mapped = 1'b1; is_external = 1'b1; end
      12'h342: begin old_val = csr_mcause_i;  mapped = 1'b1; is_external = 1'b1; end
      12'h344: begin old_val = csr_mip_i;     mapped = 1'b1; is_external = 1'b1; end
      12'hB00, 12'hC00: begin old_val = cycle_reg[31:0];   mapped = 1'b1; end
      12'hB80, 12'hC80: begin old_val = 32'(cycle_reg[CNT_WIDTH-1:32]);   mapped = 1'b1; end
      12'hB02, 12'hC02: begin old_val = instret_reg[31:0]; mapped = 1'b1; end
      12'hB82, 12'hC82: begin old_val = 32'(instret_reg[CNT_WIDTH-1:32]); mapped = 1'b1; end
      12'hC01: begin old_val = csr_time_i[31:0];              mapped = 1'b1; end
      12'hC81: begin old_val = 32'(csr_time_i[CNT_WIDTH-1:32]); mapped = 1'b1; end
      default: ;
    endcase
    if (d_csr_sel_i == 12'h340) begin
      scr_hit = 1'b1;
    end else if (d_csr_sel_i[11:4] == 8'h7C) begin
      scr_hit = 1'b1;
      scr_idx = 5'(d_csr_sel_i[3:0]) + 5'd1;
    end
    for (int k = 0; k < NUM_SCRATCH; k++) begin
      if (scr_hit && scr_idx == 5'(k)) begin
        old_val = scratch_q[k];
        mapped  = 1'b1;
      end
    end
  end

  always_comb begin
    in2 = d_fun_i[2] ? {27'd0, d_csr_imm_i} : d_rs1_i;
    case (d_fun_i[1:0])
      2'b10:   new_val = old_val | in2;
      2'b11:   new_val = old_val & ~in2;
      default: new_val = in2;
    endcase
  end

  // A half-write replaces that half; the other half sees no carry across the boundary.
  always_comb begin
    cycle_next   = cycle_reg + CNT_ONE;
    instret_next = instret_reg + {{(CNT_WIDTH-1){1'b0}}, x_retire_i};
    if (do_write && d_csr_sel_i == 12'hB00)
      cycle_next = {cycle_reg[CNT_WIDTH-1:32], new_val};
    else if (do_write && d_csr_sel_i == 12'hB80)
      cycle_next = {new_val[HW-1:0], cycle_reg[31:0] + 32'd1};
    if (do_write && d_csr_sel_i == 12'hB02)
      instret_next = {instret_reg[CNT_WIDTH-1:32], new_val};
    else if (do_write && d_csr_sel_i == 12'hB82)
      instret_next = {new_val[HW-1:0], instret_reg[31:0] + {31'd0, x_retire_i}};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      cycle_reg   <= cycle_next;
      instret_reg <= instret_next;
    end
  end

  for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
    logic [31:0] scratch_reg;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
        scratch_reg <= 32'd0;
      else if (do_write && scr_hit && scr_idx == 5'(gi))
        scratch_reg <= new_val;
    end
    assign scratch_q[gi] = scratch_reg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_rd_o              <= 32'd0;
      x_csr_we_o          <= 1'b0;
      x_csr_sel_o         <= 12'd0;
      x_csr_write_value_o <= 32'd0;
      x_illegal_o         <= 1'b0;
    end else begin
      x_csr_we_o  <= 1'b0;
      x_illegal_o <= 1'b0;
      if (accept) begin
        x_illegal_o <= illegal;
        if (!illegal) begin
          x_rd_o <= old_val;
          if (wr_req && is_external) begin
            x_csr_we_o          <= 1'b1;
            x_csr_sel_o         <= d_csr_sel_i;
            x_csr_write_value_o <= new_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_urv_csr_unit.sv
// Directed bench for urv_csr_unit: expected results are queued at issue time
// and checked one cycle later when the registered outputs appear.
module tb_urv_csr_unit;
  localparam int CW = 40;
  localparam int NS = 4;
  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          x_stall_i = 1'b0, x_kill_i = 1'b0, x_retire_i = 1'b0;
  logic          d_is_csr_i = 1'b0;
  logic [2:0]    d_fun_i = 3'd0;
  logic [4:0]    d_csr_imm_i = 5'd0;
  logic [11:0]   d_csr_sel_i = 12'd0;
  logic [31:0]   d_rs1_i = 32'd0;
  logic [CW-1:0] csr_time_i = 40'hAB_1234_5678;
  logic [31:0]   csr_mstatus_i = 32'h0000_188F, csr_mip_i = 32'h0000_0080;
  logic [31:0]   csr_mie_i = 32'h0000_0008, csr_mtvec_i = 32'h8000_0100;
  logic [31:0]   csr_mepc_i = 32'h0000_0100, csr_mcause_i = 32'h8000_000B;
  logic [31:0]   x_rd_o;
  logic          x_csr_we_o;
  logic [11:0]   x_csr_sel_o;
  logic [31:0]   x_csr_write_value_o;
  logic          x_illegal_o;

  urv_csr_unit #(.CNT_WIDTH(CW), .NUM_SCRATCH(NS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .x_retire_i(x_retire_i), .d_is_csr_i(d_is_csr_i), .d_fun_i(d_fun_i),
    .d_csr_imm_i(d_csr_imm_i), .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i),
    .csr_time_i(csr_time_i), .csr_mstatus_i(csr_mstatus_i), .csr_mip_i(csr_mip_i),
    .csr_mie_i(csr_mie_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mcause_i(csr_mcause_i), .x_rd_o(x_rd_o), .x_csr_we_o(x_csr_we_o),
    .x_csr_sel_o(x_csr_sel_o), .x_csr_write_value_o(x_csr_write_value_o),
    .x_illegal_o(x_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        chk_rd;
    logic        we;
    logic [11:0] sel;
    logic [31:0] val;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          txn = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/rd"},  x_rd_o, 32'd0);
    chk({tag, "/we"},  32'(x_csr_we_o), 32'd0);
    chk({tag, "/sel"}, 32'(x_csr_sel_o), 32'd0);
    chk({tag, "/val"}, x_csr_write_value_o, 32'd0);
    chk({tag, "/ill"}, 32'(x_illegal_o), 32'd0);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      $display("txn %0d %s: rd=%h we=%b sel=%h val=%h ill=%b", txn, e.tag,
               x_rd_o, x_csr_we_o, x_csr_sel_o, x_csr_write_value_o, x_illegal_o);
      if (e.chk_rd) chk({e.tag, "/rd"}, x_rd_o, e.rd);
      chk({e.tag, "/we"},  32'(x_csr_we_o), 32'(e.we));
      chk({e.tag, "/ill"}, 32'(x_illegal_o), 32'(e.ill));
      if (e.we) begin
        chk({e.tag, "/sel"}, 32'(x_csr_sel_o), 32'(e.sel));
        chk({e.tag, "/val"}, x_csr_write_value_o, e.val);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    exp_t e;
    e.tag = tag; e.rd = last_rd; e.chk_rd = 1'b1;
    e.we = 1'b0; e.sel = 12'd0; e.val = 32'd0; e.ill = 1'b0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    d_is_csr_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      expect_idle("idle");
      step();
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] fun, input logic [4:0] imm,
                       input logic [11:0] sel, input logic [31:0] rs1, input logic kill,
                       input logic [31:0] e_rd, input logic e_chk, input logic e_we,
                       input logic [31:0] e_val, input logic e_ill);
    exp_t e;
    d_is_csr_i = 1'b1; d_fun_i = fun; d_csr_imm_i = imm;
    d_csr_sel_i = sel; d_rs1_i = rs1; x_kill_i = kill;
    e.tag = tag; e.sel = sel; e.val = e_val; e.chk_rd = e_chk;
    if (kill) begin
      e.rd = last_rd; e.we = 1'b0; e.ill = 1'b0;
    end else begin
      e.we = e_we; e.ill = e_ill;
      e.rd = e_ill ? last_rd : e_rd;
    end
    last_rd = e.rd;
    sb.push_back(e);
    step();
    d_is_csr_i = 1'b0; x_kill_i = 1'b0;
  endtask

  initial begin
    #1;
    chk_reset_outputs("por");
    @(negedge clk_i);
    rst_i = 1'b0;

    issue("pre_wr",  RW, 5'd1, 12'h340, 32'h55, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("pre_rd",  RS, 5'd0, 12'h340, 32'h0,  1'b0, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(3);

    // Asynchronous reset between edges, released on a falling edge.
    #3 rst_i = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    last_rd = 32'd0;
    idle(4);
    issue("cycle_after_rst", RS, 5'd0, 12'hC00, 32'h0, 1'b0, 32'd4, 1'b1, 1'b0, 32'h0, 1'b0);

    x_stall_i = 1'b1; x_retire_i = 1'b1;
    d_is_csr_i = 1'b1; d_fun_i = RW; d_csr_imm_i = 5'd3; d_csr_sel_i = 12'h340; d_rs1_i = 32'hAAAA;
    for (int i = 0; i < 7; i++) begin
      expect_idle("stall_retire");
      step();
    end
    x_stall_i = 1'b0; x_retire_i = 1'b0; d_is_csr_i = 1'b0;
    issue("instret_rd",  RS, 5'd0, 12'hC02, 32'h0, 1'b0, 32'd7, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("minstret_rd", RS, 5'd0, 12'hB02, 32'h0, 1'b0, 32'd7, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("mscr_after_stall", RS, 5'd0, 12'h340, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    issue("mscr_rw",  RW, 5'd5, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0);
    issue("mscr_rs",  RS, 5'd6, 12'h340, 32'h0000_00F0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("mscr_rd0", RS, 5'd0, 12'h340, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEFF, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("mscr_rd1", RC, 5'd0, 12'h340, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEFF, 1'b1, 1'b0, 32'h0, 1'b0);

    issue("scr2_rwi", RWI, 5'd5, 12'h7C2, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("scr2_rd",  RSI, 5'd0, 12'h7C2, 32'h0,  1'b0, 32'h5,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("scr3_oob", RW,  5'd1, 12'h7C3, 32'h9,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1);
    issue("scr0_rw",  RW,  5'd1, 12'h7C0, 32'h77, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("scr0_rd",  RS,  5'd0, 12'h7C0, 32'h0,  1'b0, 32'h77, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("scr2_keep", RS, 5'd0, 12'h7C2, 32'h0,  1'b0, 32'h5,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("scrF_oob", RS,  5'd0, 12'h7CF, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1);

    issue("mstatus_rci", RCI, 5'd8, 12'h300, 32'h0, 1'b0, 32'h188F, 1'b1, 1'b1, 32'h1887, 1'b0);
    idle(1);
    issue("mstatus_kill", RCI, 5'd8, 12'h300, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h1887, 1'b0);
    issue("mepc_rw",   RW,  5'd2,  12'h341, 32'h8000_1000, 1'b0, 32'h100, 1'b1, 1'b1, 32'h8000_1000, 1'b0);
    issue("mie_rs",    RS,  5'd4,  12'h304, 32'h3,         1'b0, 32'h8,   1'b1, 1'b1, 32'hB, 1'b0);
    issue("mip_rsi0",  RSI, 5'd0,  12'h344, 32'h0,         1'b0, 32'h80,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("mtvec_rwi", RWI, 5'h1F, 12'h305, 32'h0,         1'b0, 32'h8000_0100, 1'b1, 1'b1, 32'h1F, 1'b0);
    issue("mcause_rc", RC,  5'd9,  12'h342, 32'hFFFF_FFFF, 1'b0, 32'h8000_000B, 1'b1, 1'b1, 32'h0, 1'b0);

    issue("ro_rw",    RW,  5'd1, 12'hC00, 32'h5, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    issue("ro_rsi",   RSI, 5'd1, 12'hC02, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    issue("unmapped", RS,  5'd0, 12'h123, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    issue("time_hi",  RS,  5'd0, 12'hC81, 32'h0, 1'b0, 32'hAB,        1'b1, 1'b0, 32'h0, 1'b0);
    issue("time_lo",  RS,  5'd0, 12'hC01, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);

    // Low half parked at all-ones so the next edge's increment wraps without carry.
    issue("mcycle_lo_wr", RW, 5'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0);
    issue("mcycle_hi_wr", RW, 5'd1, 12'hB80, 32'h12,        1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("mcycle_hi_rd", RS, 5'd0, 12'hB80, 32'h0,         1'b0, 32'h12, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("mcycle_lo_rd", RS, 5'd0, 12'hB00, 32'h0,         1'b0, 32'h1,  1'b1, 1'b0, 32'h0, 1'b0);
    issue("cycle_hi_rd",  RS, 5'd0, 12'hC80, 32'h0,         1'b0, 32'h12, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("cycle_lo_rd",  RS, 5'd0, 12'hC00, 32'h0,         1'b0, 32'h3,  1'b1, 1'b0, 32'h0, 1'b0);

    x_retire_i = 1'b1;
    issue("minstret_lo_wr", RW, 5'd1, 12'hB02, 32'hFFFF_FFFF, 1'b0, 32'd7, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("minstret_hi_wr", RW, 5'd1, 12'hB82, 32'h5,         1'b0, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    x_retire_i = 1'b0;
    issue("minstret_hi_rd", RS, 5'd0, 12'hB82, 32'h0, 1'b0, 32'h5, 1'b1, 1'b0, 32'h0, 1'b0);
    issue("minstret_lo_rd", RS, 5'd0, 12'hB02, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
